axil_slave_regfile: RTL and testbench
=====================================

// Module: axil_slave_regfile
// PURPOSE
//  Parametrised AXI4-Lite slave with a memory-mapped register file; successor to the fixed 32-bit Slave_Interface.
//  Generalised in data width and register count. Adds byte strobes and independent AW/W acceptance.
//  Adds an OKAY/SLVERR response on B and R, and exposes the register contents to the user logic.
//  Sits between the AXI-Lite interconnect (or Master_Interface) and control/status logic.
// PARAMETERS
//  DATA_WIDTH  32  bus/register width; 32 or 64
//  ADDR_WIDTH  32  byte address width
//  NUM_REGS    8   register count, >=2; need not be a power of two
//  RESET_VAL   0   reset value of every register
// PORTS
//  ACLK      in   1                    clock; single clock domain
//  ARESETN   in   1                    asynchronous active-low reset
//  AWADDR    in   ADDR_WIDTH           write byte address
//  AWVALID   in   1                    write address valid
//  AWREADY   out  1                    write address ready
//  WDATA     in   DATA_WIDTH           write data
//  WSTRB     in   DATA_WIDTH/8         write byte strobes
//  WVALID    in   1                    write data valid
//  WREADY    out  1                    write data ready
//  BRESP     out  2                    write response
//  BVALID    out  1                    write response valid
//  BREADY    in   1                    write response ready
//  ARADDR    in   ADDR_WIDTH           read byte address
//  ARVALID   in   1                    read address valid
//  ARREADY   out  1                    read address ready
//  RDATA     out  DATA_WIDTH           read data
//  RRESP     out  2                    read response
//  RVALID    out  1                    read data valid
//  RREADY    in   1                    read data ready
//  REG_OUT   out  NUM_REGS*DATA_WIDTH  flat register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//  WR_PULSE  out  NUM_REGS             one-cycle pulse in the cycle after reg i is written
// BEHAVIOUR
//  Reset (async, ARESETN=0):
//   - All READY, BVALID, RVALID and WR_PULSE = 0; BRESP, RRESP, RDATA = 0.
//   - Every register = RESET_VAL; AW/W holding slots empty.
//   - A reset mid-transaction drops the transaction; there is no response afterwards.
//  Addressing: idx = ADDR[LSB +: IDX_W], LSB = clog2(DATA_WIDTH/8), IDX_W = clog2(NUM_REGS).
//   - Address bits above idx are ignored. Address bits below LSB are ignored.
//  Write channel:
//   - AW and W each have a one-entry holding slot.
//   - AWREADY = ~aw_full & ~BVALID; WREADY = ~w_full & ~BVALID. Both are registered.
//   - AW and W may arrive in either order or in the same cycle.
//   - In the cycle both slots are full, the write commits:
//     - byte k is updated only when WSTRB[k]=1;
//     - both slots clear;
//     - BVALID rises on the next edge;
//     - WR_PULSE[idx] = 1 for exactly one cycle, aligned with the BVALID rise.
//   - BVALID and BRESP are held until BREADY. No new AW/W is accepted while BVALID=1.
//   - Minimum latency from the AW+W handshake edge to BVALID is 2 cycles.
//   - WSTRB=0 commits nothing to the register, still pulses WR_PULSE, and returns OKAY.
//  Read channel:
//   - ARREADY = ~RVALID.
//   - On the AR handshake, RDATA and RRESP are registered and RVALID rises on the next edge.
//   - RDATA, RRESP and RVALID are held stable until RREADY.
//   - Read and write paths are independent and may be active in the same cycle.
//   - A read and a write commit to the same idx in the same cycle: the read returns the pre-write value.
//  Out-of-range (idx >= NUM_REGS): see CONFIGURATION.
//  States: write FSM W_IDLE -> W_HOLD (one slot full) -> W_RESP (BVALID) -> W_IDLE; read FSM R_IDLE <-> R_RESP.
// CONFIGURATION
//  AXIL_SLVERR_EN:
//   - defined: an out-of-range write is discarded with BRESP=SLVERR(2'b10) and no WR_PULSE;
//     an out-of-range read returns RDATA=0 with RRESP=SLVERR.
//   - undefined: idx wraps modulo NUM_REGS, and every response is OKAY(2'b00).
// STRUCTURE
//  - axil_pkg (shared header) holds RESP_OKAY, RESP_SLVERR and the clog2 function; it is reused by Master_Interface.
//  - One sub-module, axil_hold_slot (DATA+valid one-entry slot with set/clear), is instantiated twice, for AW and W.
//  - The register array and the FSMs live in the top.
// TESTING
//  1 Reset: after ARESETN rises, read 0x00..0x1C -> RDATA=RESET_VAL, RRESP=OKAY, and every READY timing matches.
//  2 AW and W in the same cycle:
//    - write 0x08 data 0x2564, WSTRB=4'hF -> BVALID 2 cycles later with OKAY, WR_PULSE[2] for one cycle;
//    - a read of 0x08 returns 0x2564.
//  3 W three cycles before AW: write 0x04 data 0xDEADBEEF, WSTRB=4'b0101 onto 0 -> the register reads 0x00AD00EF.
//  4 Backpressure:
//    - hold BREADY=0 for 5 cycles -> BVALID/BRESP stable, AWREADY=WREADY=0;
//    - hold RREADY=0 for 5 cycles -> RDATA stable.
//  5 Out-of-range, NUM_REGS=8: write 0x20 data 0x1.
//    - with AXIL_SLVERR_EN -> BRESP=2'b10, reg0 unchanged, read 0x20 gives RRESP=2'b10 and RDATA=0;
//    - without it -> reg0=1, OKAY.
//  6 Collision and reset:
//    - a same-cycle read/commit to 0x0C returns the old value;
//    - ARESETN low while BVALID=1 -> BVALID=0 immediately and the registers return to RESET_VAL.

Source files
------------

// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared AXI4-Lite definitions used by the slave register file and by the
// master-side interface logic.
//   RESP_OKAY / RESP_SLVERR : B/R channel response codes
//   w_state_e / r_state_e   : write and read channel FSM encodings
//   clog2()                 : constant ceiling-log2 for parameter derivation
// -----------------------------------------------------------------------------
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_HOLD = 2'b01,
        W_RESP = 2'b10
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

    // Smallest r with 2**r >= value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axil_hold_slot.sv
// -----------------------------------------------------------------------------
// axil_hold_slot
// One-entry holding slot (payload + full flag) used to park an accepted AW or
// W beat until its partner arrives.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   set           : load din and mark the slot full
//   clr           : empty the slot (wins over set)
//   din / dout    : payload in / held payload
//   full          : slot holds a valid payload
// -----------------------------------------------------------------------------
module axil_hold_slot #(
    parameter int WIDTH = 32
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             set,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    logic             full_r;
    logic [WIDTH-1:0] data_r;

    // Slot storage: clear on commit, capture on handshake, otherwise hold.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else if (clr) begin
            full_r <= 1'b0;
        end else if (set) begin
            full_r <= 1'b1;
            data_r <= din;
        end
    end

    assign full = full_r;
    assign dout = data_r;

endmodule

// File: rtl/axil_slave_regfile.sv
// -----------------------------------------------------------------------------
// axil_slave_regfile
// AXI4-Lite slave exposing NUM_REGS registers of DATA_WIDTH bits.
//   ACLK, ARESETN            : clock, asynchronous active-low reset
//   AW*/W*/B*                : write address, data (with byte strobes), response
//   AR*/R*                   : read address, data/response
//   REG_OUT                  : flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   WR_PULSE                 : one-cycle pulse, aligned with BVALID rising, for the written reg
// AW and W are parked in independent one-entry slots; the write commits in the
// cycle both are full, and BVALID/WR_PULSE follow one cycle after the register
// update. All handshake outputs are registered.
// Build option: define AXIL_SLVERR_EN to reject out-of-range word addresses
// with SLVERR; otherwise the index wraps modulo NUM_REGS and responses are OKAY.
// -----------------------------------------------------------------------------
module axil_slave_regfile
    import axil_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT,
    output logic [NUM_REGS-1:0]            WR_PULSE
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = clog2(STRB_W);
    localparam int IDX_W  = clog2(NUM_REGS);

    // Index from the address; the modulo only matters for non-power-of-two NUM_REGS.
    function automatic logic [IDX_W-1:0] addr_to_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [IDX_W-1:0] raw;
        raw = addr[LSB +: IDX_W];
        return IDX_W'(int'(raw) % NUM_REGS);
    endfunction

    logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];

    w_state_e              w_state_r, w_state_s;
    r_state_e              r_state_r, r_state_s;
    logic                  awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [1:0]            bresp_r, rresp_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [NUM_REGS-1:0]   wr_pulse_r, pulse_pend_r;

    logic                  aw_full_s, w_full_s;
    logic [ADDR_WIDTH-1:0] aw_addr_s;
    logic [DATA_WIDTH-1:0] w_data_s;
    logic [STRB_W-1:0]     w_strb_s;
    logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s;
    logic                  aw_full_n_s, w_full_n_s, bvalid_n_s;
    logic [NUM_REGS-1:0]   wr_pulse_n_s;
    logic [IDX_W-1:0]      w_idx_s, r_idx_s;
    logic                  w_ok_s, r_ok_s;
    logic                  unused_s;

    assign aw_hs_s  = AWVALID & awready_r;
    assign w_hs_s   = WVALID & wready_r;
    assign ar_hs_s  = ARVALID & arready_r;
    assign commit_s = aw_full_s & w_full_s;

    axil_hold_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .set     (aw_hs_s),
        .clr     (commit_s),
        .din     (AWADDR),
        .full    (aw_full_s),
        .dout    (aw_addr_s)
    );

    axil_hold_slot #(.WIDTH(DATA_WIDTH + STRB_W)) u_w_slot (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .set     (w_hs_s),
        .clr     (commit_s),
        .din     ({WSTRB, WDATA}),
        .full    (w_full_s),
        .dout    ({w_strb_s, w_data_s})
    );

    // Address decode for the held write address and the incoming read address.
    // With SLVERR enabled the whole word address is range-checked, so aliases
    // above the register window are rejected rather than folded back in.
    always_comb begin
        w_idx_s = addr_to_idx(aw_addr_s);
        r_idx_s = addr_to_idx(ARADDR);
`ifdef AXIL_SLVERR_EN
        w_ok_s  = (aw_addr_s >> LSB) < ADDR_WIDTH'(NUM_REGS);
        r_ok_s  = (ARADDR >> LSB) < ADDR_WIDTH'(NUM_REGS);
`else
        w_ok_s  = 1'b1;
        r_ok_s  = 1'b1;
`endif
    end

    // Address bits outside the index field are intentionally ignored.
    assign unused_s = ^{aw_addr_s, ARADDR};

    // Write FSM next state, next slot occupancy and B/pulse next values.
    always_comb begin
        w_state_s    = w_state_r;
        aw_full_n_s  = aw_full_s;
        w_full_n_s   = w_full_s;
        bvalid_n_s   = bvalid_r;
        wr_pulse_n_s = '0;
        case (w_state_r)
            W_IDLE, W_HOLD: begin
                if (commit_s) begin
                    aw_full_n_s = 1'b0;
                    w_full_n_s  = 1'b0;
                    w_state_s   = W_RESP;
                end else begin
                    aw_full_n_s = aw_full_s | aw_hs_s;
                    w_full_n_s  = w_full_s | w_hs_s;
                    if (aw_full_n_s | w_full_n_s) begin
                        w_state_s = W_HOLD;
                    end else begin
                        w_state_s = W_IDLE;
                    end
                end
            end
            W_RESP: begin
                // First W_RESP cycle raises BVALID together with the pulse.
                if (!bvalid_r) begin
                    wr_pulse_n_s = pulse_pend_r;
                end else begin
                    wr_pulse_n_s = '0;
                end
                if (bvalid_r && BREADY) begin
                    bvalid_n_s = 1'b0;
                    w_state_s  = W_IDLE;
                end else begin
                    bvalid_n_s = 1'b1;
                    w_state_s  = W_RESP;
                end
            end
            default: begin
                w_state_s = W_IDLE;
            end
        endcase
    end

    // Write control registers: state, READYs derived from next occupancy, B channel.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_r    <= W_IDLE;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            bvalid_r     <= 1'b0;
            bresp_r      <= RESP_OKAY;
            wr_pulse_r   <= '0;
            pulse_pend_r <= '0;
        end else begin
            w_state_r  <= w_state_s;
            awready_r  <= ~aw_full_n_s & (w_state_s != W_RESP);
            wready_r   <= ~w_full_n_s & (w_state_s != W_RESP);
            bvalid_r   <= bvalid_n_s;
            wr_pulse_r <= wr_pulse_n_s;
            if (commit_s) begin
                pulse_pend_r <= w_ok_s ? (NUM_REGS'(1) << w_idx_s) : '0;
                bresp_r      <= w_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Register array: byte-strobed update on commit.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
        end else if (commit_s && w_ok_s) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (w_strb_s[k]) begin
                    regs_r[w_idx_s][k*8 +: 8] <= w_data_s[k*8 +: 8];
                end
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_state_s = R_RESP;
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    r_state_s = R_IDLE;
                end else begin
                    r_state_s = R_RESP;
                end
            end
            default: begin
                r_state_s = R_IDLE;
            end
        endcase
    end

    // Read channel registers; capture happens before any same-edge write lands.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_r <= R_IDLE;
            rvalid_r  <= 1'b0;
            arready_r <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_s;
            rvalid_r  <= (r_state_s == R_RESP);
            arready_r <= (r_state_s != R_RESP);
            if (ar_hs_s) begin
                rdata_r <= r_ok_s ? regs_r[r_idx_s] : '0;
                rresp_r <= r_ok_s ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_reg_out
            assign REG_OUT[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
        end
    endgenerate

    assign AWREADY  = awready_r;
    assign WREADY   = wready_r;
    assign BVALID   = bvalid_r;
    assign BRESP    = bresp_r;
    assign WR_PULSE = wr_pulse_r;
    assign ARREADY  = arready_r;
    assign RVALID   = rvalid_r;
    assign RDATA    = rdata_r;
    assign RRESP    = rresp_r;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for axil_slave_regfile with default parameters
// (32-bit data, 32-bit address, 8 registers, reset value 0).
module tb_axil_slave_regfile;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 8;
    localparam int LIMIT = 20;

    logic              ACLK;
    logic              ARESETN;
    logic [AW-1:0]     AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DW-1:0]     WDATA;
    logic [DW/8-1:0]   WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [AW-1:0]     ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic [NR*DW-1:0]  REG_OUT;
    logic [NR-1:0]     WR_PULSE;

    int n_tests = 0;
    int n_fail  = 0;

    axil_slave_regfile #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .RESET_VAL  (32'h0000_0000)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .REG_OUT  (REG_OUT),
        .WR_PULSE (WR_PULSE)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_bvalid();
        int n;
        n = 0;
        while (!BVALID && n < LIMIT) begin
            tick();
            n++;
        end
        chk("bvalid_wait", (n < LIMIT), 1'b1);
    endtask

    // AW and W presented together; returns with BVALID visible, BREADY low.
    task automatic start_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
        int n;
        AWADDR  = addr;
        WDATA   = data;
        WSTRB   = strb;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        n = 0;
        while (!(AWREADY && WREADY) && n < LIMIT) begin
            tick();
            n++;
        end
        chk("wr_ready_wait", (n < LIMIT), 1'b1);
        tick();
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        wait_bvalid();
    endtask

    task automatic finish_b();
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
    endtask

    // Returns with RVALID visible, RREADY low.
    task automatic start_read(input logic [AW-1:0] addr);
        int n;
        ARADDR  = addr;
        ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < LIMIT) begin
            tick();
            n++;
        end
        chk("ar_ready_wait", (n < LIMIT), 1'b1);
        tick();
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < LIMIT) begin
            tick();
            n++;
        end
        chk("rvalid_wait", (n < LIMIT), 1'b1);
    endtask

    task automatic finish_r();
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [AW-1:0] addr,
                            input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
        start_read(addr);
        chk({tag, "_rdata"}, RDATA, exp_data);
        chk({tag, "_rresp"}, RRESP, exp_resp);
        finish_r();
    endtask

    initial begin
        ARESETN = 1'b0;
        AWADDR  = 32'h0;
        AWVALID = 1'b0;
        WDATA   = 32'h0;
        WSTRB   = 4'h0;
        WVALID  = 1'b0;
        BREADY  = 1'b0;
        ARADDR  = 32'h0;
        ARVALID = 1'b0;
        RREADY  = 1'b0;

        // ---- 1: reset state and READY timing ----
        repeat (3) tick();
        chk("rst_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
        chk("rst_valids", {BVALID, RVALID, WR_PULSE}, 10'h000);
        chk("rst_resp_data", {BRESP, RRESP, RDATA}, 36'h0);
        chk("rst_regs", REG_OUT, '0);
        ARESETN = 1'b1;
        #1;
        chk("release_readys_before_edge", {AWREADY, WREADY, ARREADY}, 3'b000);
        tick();
        chk("release_readys_after_edge", {AWREADY, WREADY, ARREADY}, 3'b111);
        for (int a = 0; a < NR; a++) begin
            read_chk("reset_read", AW'(a * 4), 32'h0000_0000, 2'b00);
        end

        // ---- 2: AW and W in the same cycle, exact latency ----
        AWADDR  = 32'h08;
        WDATA   = 32'h0000_2564;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        tick();                                   // handshake edge
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        chk("t2_after_hs", {BVALID, AWREADY, WREADY, WR_PULSE}, 11'h000);
        tick();                                   // commit edge
        chk("t2_commit_no_b", {BVALID, WR_PULSE}, 9'h000);
        chk("t2_reg2_written", REG_OUT[2*DW +: DW], 32'h0000_2564);
        tick();
        chk("t2_bvalid_2cyc", {BVALID, BRESP, WR_PULSE}, 11'b1_00_00000100);
        tick();
        chk("t2_pulse_one_cycle", {BVALID, WR_PULSE}, 9'b1_00000000);
        finish_b();
        chk("t2_b_done", {BVALID, AWREADY, WREADY}, 3'b011);
        read_chk("t2_read", 32'h08, 32'h0000_2564, 2'b00);

        // ---- 3: W three cycles before AW, partial strobes ----
        WDATA  = 32'hDEAD_BEEF;
        WSTRB  = 4'b0101;
        WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("t3_w_parked", {WREADY, AWREADY, BVALID}, 3'b010);
        repeat (3) tick();
        AWADDR  = 32'h04;
        AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        wait_bvalid();
        chk("t3_bresp", BRESP, 2'b00);
        finish_b();
        chk("t3_reg1", REG_OUT[1*DW +: DW], 32'h00AD_00EF);
        read_chk("t3_read", 32'h04, 32'h00AD_00EF, 2'b00);

        // ---- 4: backpressure on B and R ----
        start_write(32'h10, 32'h1234_5678, 4'hF);
        for (int c = 0; c < 5; c++) begin
            chk("t4_b_hold", {BVALID, BRESP, AWREADY, WREADY}, 5'b1_00_0_0);
            tick();
        end
        finish_b();
        start_read(32'h10);
        for (int c = 0; c < 5; c++) begin
            chk("t4_r_hold", {RVALID, RRESP, ARREADY, RDATA}, {1'b1, 2'b00, 1'b0, 32'h1234_5678});
            tick();
        end
        finish_r();

        // ---- 5: out-of-range address ----
        start_write(32'h20, 32'h0000_0001, 4'hF);
`ifdef AXIL_SLVERR_EN
        chk("t5_bresp_slverr", BRESP, 2'b10);
        finish_b();
        chk("t5_reg0_unchanged", REG_OUT[0 +: DW], 32'h0);
        read_chk("t5_read_oor", 32'h20, 32'h0, 2'b10);
`else
        chk("t5_bresp_okay", BRESP, 2'b00);
        finish_b();
        chk("t5_reg0_wrapped", REG_OUT[0 +: DW], 32'h1);
        read_chk("t5_read_wrap", 32'h20, 32'h1, 2'b00);
`endif

        // ---- 6: read/commit collision, then reset during BVALID ----
        AWADDR  = 32'h0C;
        WDATA   = 32'hA5A5_A5A5;
        WSTRB   = 4'hF;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        tick();                                   // AW/W handshake
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARADDR  = 32'h0C;
        ARVALID = 1'b1;
        tick();                                   // commit and AR handshake share this edge
        ARVALID = 1'b0;
        chk("t6_collision_old", {RVALID, RDATA}, {1'b1, 32'h0});
        chk("t6_reg3_new", REG_OUT[3*DW +: DW], 32'hA5A5_A5A5);
        finish_r();
        chk("t6_bvalid_pending", BVALID, 1'b1);
        ARESETN = 1'b0;
        #1;
        chk("t6_reset_bvalid", {BVALID, AWREADY, WREADY, WR_PULSE}, 11'h000);
        chk("t6_reset_regs", REG_OUT, '0);
        tick();
        ARESETN = 1'b1;
        tick();
        chk("t6_no_resp_after_reset", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);
        read_chk("t6_read_reg3", 32'h0C, 32'h0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
